// File: rtl/cam_ram_multimode_config.sv
// rtl/cam_ram_multimode_config.sv - CAM/RAM with valid bits, per-port compare modes and multi-cycle init
module cam_ram_multimode_config #(
   parameter int DEPTH            = 32,
   parameter int INDEX            = 5,
   parameter int WIDTH            = 8,
   parameter int NUM_WR_PORTS     = 2,
   parameter int NUM_CAM_RD_PORTS = 2,
   parameter int NUM_RAM_RD_PORTS = 2,
   parameter int RESET_VAL        = 0,
   parameter int SEQ_START        = 0,
   parameter int INIT_PER_CYCLE   = 4,
   parameter int CNT_W            = 6
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_WR_PORTS-1:0]             writePortGated_i,
   input  logic [NUM_CAM_RD_PORTS-1:0]         readPortGated_i,
   input  logic [NUM_WR_PORTS-1:0]             wrEn_i,
   input  logic [NUM_WR_PORTS*INDEX-1:0]       addrWr_i,
   input  logic [NUM_WR_PORTS*WIDTH-1:0]       dataWr_i,
   input  logic                                invEn_i,
   input  logic [INDEX-1:0]                    invAddr_i,
   input  logic                                flushAll_i,
   input  logic [NUM_CAM_RD_PORTS*WIDTH-1:0]   tag_i,
   input  logic [NUM_CAM_RD_PORTS*WIDTH-1:0]   mask_i,
   input  logic [NUM_CAM_RD_PORTS*2-1:0]       mode_i,
   output logic [NUM_CAM_RD_PORTS*DEPTH-1:0]   vect_o,
   output logic [NUM_CAM_RD_PORTS-1:0]         matchHit_o,
   output logic [NUM_CAM_RD_PORTS*INDEX-1:0]   matchIdx_o,
   input  logic [NUM_RAM_RD_PORTS*INDEX-1:0]   addr_i,
   output logic [NUM_RAM_RD_PORTS*WIDTH-1:0]   data_o,
   output logic [DEPTH-1:0]                    valid_o,
   output logic [CNT_W-1:0]                    validCount_o,
   output logic                                ramReady_o
);

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                  state;
   state_t                  stateNext;
   logic                    ready;
   logic [INDEX:0]          initCnt;
   logic                    ramReady;

   logic [WIDTH-1:0]        ram [DEPTH];
   logic [DEPTH-1:0]        valid;
   logic [DEPTH-1:0]        validNext;
   logic [CNT_W-1:0]        validCount;
   logic [CNT_W-1:0]        popCnt;

   logic [DEPTH-1:0]        wrHit;
   logic [WIDTH-1:0]        wrData [DEPTH];
   logic [DEPTH-1:0]        invHit;

   logic [NUM_CAM_RD_PORTS*DEPTH-1:0] camVec;

   assign ready        = (state == READY);
   assign valid_o      = valid;
   assign validCount_o = validCount;
   assign ramReady_o   = ramReady;
   assign vect_o       = camVec;

   // Unsigned compare of search key against one stored entry, selected by mode
   function automatic logic cmpFn(input logic [1:0]       m,
                                  input logic [WIDTH-1:0] t,
                                  input logic [WIDTH-1:0] mk,
                                  input logic [WIDTH-1:0] e);
      logic r;
      case (m)
         2'd0:    r = (t == e);
         2'd1:    r = (t > e);
         2'd2:    r = (t < e);
         default: r = ((t & mk) == (e & mk));
      endcase
      return r;
   endfunction

   // State register; reset always drops back into INIT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= INIT;
      end else begin
         state <= stateNext;
      end
   end

   // Leave INIT once the last group of entries is being initialised
   always_comb begin
      stateNext = state;
      case (state)
         INIT: begin
            if (initCnt == (INDEX+1)'(DEPTH - INIT_PER_CYCLE)) begin
               stateNext = READY;
            end
         end
         READY: stateNext = READY;
         default: stateNext = INIT;
      endcase
   end

   // Init pointer walks the array INIT_PER_CYCLE entries at a time
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         initCnt <= '0;
      end else if (state == INIT) begin
         initCnt <= initCnt + (INDEX+1)'(INIT_PER_CYCLE);
      end
   end

   // Ready flag rises on the same edge the FSM enters READY
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ramReady <= 1'b0;
      end else begin
         ramReady <= (stateNext == READY);
      end
   end

   // Decode qualified writes; later port indices override earlier ones on address clashes
   always_comb begin
      wrHit = '0;
      for (int k = 0; k < DEPTH; k++) begin
         wrData[k] = '0;
      end
      for (int w = 0; w < NUM_WR_PORTS; w++) begin
         if (wrEn_i[w] && !writePortGated_i[w] && ready) begin
            wrHit[addrWr_i[w*INDEX +: INDEX]]  = 1'b1;
            wrData[addrWr_i[w*INDEX +: INDEX]] = dataWr_i[w*WIDTH +: WIDTH];
         end
      end
   end

   // Valid update: a write beats invalidate, which beats flush (both of those clear)
   always_comb begin
      invHit = '0;
      if (invEn_i && ready) begin
         invHit[invAddr_i] = 1'b1;
      end
      if (ready) begin
         validNext = wrHit | (valid & ~invHit & ~{DEPTH{flushAll_i}});
      end else begin
         validNext = valid;
      end
   end

   // Entry storage: init pattern while in INIT, port writes once READY
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            ram[k] <= '0;
         end
      end else if (state == INIT) begin
         for (int j = 0; j < INIT_PER_CYCLE; j++) begin
            ram[INDEX'(initCnt) + INDEX'(j)] <= (RESET_VAL != 0)
               ? WIDTH'(SEQ_START + int'(initCnt) + j) : '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (wrHit[k]) begin
               ram[k] <= wrData[k];
            end
         end
      end
   end

   // Valid bit register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= '0;
      end else begin
         valid <= validNext;
      end
   end

   // Population count of the current valid bits
   always_comb begin
      popCnt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         popCnt = popCnt + CNT_W'(valid[k]);
      end
   end

   // Count lags valid by one cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         validCount <= '0;
      end else begin
         validCount <= popCnt;
      end
   end

   // CAM search over registered state; gated ports and INIT produce all zeros
   always_comb begin
      camVec = '0;
      for (int p = 0; p < NUM_CAM_RD_PORTS; p++) begin
         if (ready && !readPortGated_i[p]) begin
            for (int k = 0; k < DEPTH; k++) begin
               camVec[p*DEPTH + k] = valid[k] & cmpFn(mode_i[p*2 +: 2],
                                                      tag_i[p*WIDTH +: WIDTH],
                                                      mask_i[p*WIDTH +: WIDTH],
                                                      ram[k]);
            end
         end
      end
   end

   // Hit flag and lowest-index priority encoder per CAM port
   always_comb begin
      matchHit_o = '0;
      matchIdx_o = '0;
      for (int p = 0; p < NUM_CAM_RD_PORTS; p++) begin
         matchHit_o[p] = |camVec[p*DEPTH +: DEPTH];
         for (int k = DEPTH - 1; k >= 0; k--) begin
            if (camVec[p*DEPTH + k]) begin
               matchIdx_o[p*INDEX +: INDEX] = INDEX'(k);
            end
         end
      end
   end

   // Indexed read ignores valid bits; shares gating with the CAM port of the same number
   always_comb begin
      data_o = '0;
      for (int p = 0; p < NUM_RAM_RD_PORTS; p++) begin
         if (ready && !readPortGated_i[p]) begin
            data_o[p*WIDTH +: WIDTH] = ram[addr_i[p*INDEX +: INDEX]];
         end
      end
   end

endmodule

// File: tb/tb_cam_ram_multimode_config.sv
// tb/tb_cam_ram_multimode_config.sv - directed self-checking bench for cam_ram_multimode_config
module tb_cam_ram_multimode_config;

    logic        clk;
    logic        reset;
    logic [1:0]  writePortGated;
    logic [1:0]  readPortGated;
    logic [1:0]  wrEn;
    logic [9:0]  addrWr;
    logic [15:0] dataWr;
    logic        invEn;
    logic [4:0]  invAddr;
    logic        flushAll;
    logic [15:0] tag;
    logic [15:0] mask;
    logic [3:0]  mode;
    logic [63:0] vect;
    logic [1:0]  matchHit;
    logic [9:0]  matchIdx;
    logic [9:0]  addr;
    logic [15:0] data;
    logic [31:0] valid;
    logic [5:0]  validCount;
    logic        ramReady;

    int checks   = 0;
    int failures = 0;

    cam_ram_multimode_config #(
        .RESET_VAL (1),
        .SEQ_START (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .writePortGated_i (writePortGated),
        .readPortGated_i  (readPortGated),
        .wrEn_i           (wrEn),
        .addrWr_i         (addrWr),
        .dataWr_i         (dataWr),
        .invEn_i          (invEn),
        .invAddr_i        (invAddr),
        .flushAll_i       (flushAll),
        .tag_i            (tag),
        .mask_i           (mask),
        .mode_i           (mode),
        .vect_o           (vect),
        .matchHit_o       (matchHit),
        .matchIdx_o       (matchIdx),
        .addr_i           (addr),
        .data_o           (data),
        .valid_o          (valid),
        .validCount_o     (validCount),
        .ramReady_o       (ramReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; writePortGated = '0; readPortGated = '0; wrEn = '0;
        addrWr = '0; dataWr = '0; invEn = 1'b0; invAddr = '0; flushAll = 1'b0;
        tag = '0; mask = '0; mode = '0; addr = 10'd3;
        tick(); tick();
        chk("rst_ready", 64'(ramReady), 64'(1'b0));
        chk("rst_valid", 64'(valid), 64'(32'h0));
        chk("rst_count", 64'(validCount), 64'(6'd0));
        chk("rst_data", 64'(data), 64'(16'h0));

        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("init_ready_low", 64'(ramReady), 64'(1'b0));
            chk("init_hit_low", 64'(matchHit), 64'(2'b00));
            tick();
        end
        chk("init_ready_high", 64'(ramReady), 64'(1'b1));

        addr = {5'd31, 5'd3}; tag = {8'h00, 8'h07}; mode = 4'b0000; #1;
        chk("seq_addr3", 64'(data[7:0]), 64'(8'h07));
        chk("seq_addr31", 64'(data[15:8]), 64'(8'h23));
        chk("seq_valid", 64'(valid), 64'(32'h0));
        chk("seq_nohit", 64'(matchHit[0]), 64'(1'b0));
        chk("seq_idx0", 64'(matchIdx[4:0]), 64'(5'd0));

        wrEn = 2'b01; addrWr = {5'd0, 5'd5}; dataWr = {8'h00, 8'h2A};
        tick();
        wrEn = 2'b00; tag = {8'h00, 8'h2A}; #1;
        chk("wr5_valid", 64'(valid), 64'(32'h0000_0020));
        chk("wr5_count_lag", 64'(validCount), 64'(6'd0));
        chk("wr5_vect", 64'(vect[31:0]), 64'(32'h0000_0020));
        chk("wr5_hit", 64'(matchHit[0]), 64'(1'b1));
        chk("wr5_idx", 64'(matchIdx[4:0]), 64'(5'd5));
        tick();
        chk("wr5_count", 64'(validCount), 64'(6'd1));

        wrEn = 2'b11; addrWr = {5'd9, 5'd2}; dataWr = {8'h30, 8'h10};
        invEn = 1'b1; invAddr = 5'd5;
        tick();
        wrEn = 2'b00; invEn = 1'b0;
        chk("wr29_valid", 64'(valid), 64'(32'h0000_0204));
        tick();
        chk("wr29_count", 64'(validCount), 64'(6'd2));
        tag = {8'h20, 8'h20}; mode = {2'd2, 2'd1}; #1;
        chk("gt_vect", 64'(vect[31:0]), 64'(32'h0000_0004));
        chk("gt_idx", 64'(matchIdx[4:0]), 64'(5'd2));
        chk("lt_vect", 64'(vect[63:32]), 64'(32'h0000_0200));
        chk("lt_idx", 64'(matchIdx[9:5]), 64'(5'd9));
        tag = {8'h20, 8'h3F}; mask = {8'h00, 8'hF0}; mode = {2'd2, 2'd3}; #1;
        chk("meq_vect", 64'(vect[31:0]), 64'(32'h0000_0200));
        chk("meq_idx", 64'(matchIdx[4:0]), 64'(5'd9));
        tag = {8'h20, 8'h2A}; mode = {2'd2, 2'd0}; addr = {5'd5, 5'd2}; #1;
        chk("inv_nohit", 64'(matchHit[0]), 64'(1'b0));
        chk("inv_stale", 64'(data[15:8]), 64'(8'h2A));

        wrEn = 2'b11; addrWr = {5'd4, 5'd4}; dataWr = {8'h22, 8'h11};
        invEn = 1'b1; invAddr = 5'd4; flushAll = 1'b1;
        tick();
        wrEn = 2'b00; invEn = 1'b0; flushAll = 1'b0; addr = {5'd2, 5'd4}; #1;
        chk("col_valid", 64'(valid), 64'(32'h0000_0010));
        chk("col_data4", 64'(data[7:0]), 64'(8'h22));
        chk("col_flush_keeps", 64'(data[15:8]), 64'(8'h10));
        tick();
        chk("col_count", 64'(validCount), 64'(6'd1));

        writePortGated = 2'b10; wrEn = 2'b10; addrWr = {5'd6, 5'd0}; dataWr = {8'h55, 8'h00};
        tick();
        wrEn = 2'b00; writePortGated = 2'b00;
        readPortGated = 2'b01; tag = {8'h22, 8'h22}; mode = 4'b0000; addr = {5'd6, 5'd4}; #1;
        chk("gwr_valid", 64'(valid), 64'(32'h0000_0010));
        chk("gwr_data6", 64'(data[15:8]), 64'(8'h0A));
        chk("grd_vect0", 64'(vect[31:0]), 64'(32'h0));
        chk("grd_hit0", 64'(matchHit[0]), 64'(1'b0));
        chk("grd_data0", 64'(data[7:0]), 64'(8'h00));
        chk("grd_hit1", 64'(matchHit[1]), 64'(1'b1));
        chk("grd_idx1", 64'(matchIdx[9:5]), 64'(5'd4));
        readPortGated = 2'b00;

        wrEn = 2'b11; addrWr = {5'd1, 5'd0}; dataWr = {8'h02, 8'h01};
        tick();
        wrEn = 2'b00;
        tick();
        chk("pre_rst_valid", 64'(valid), 64'(32'h0000_0013));
        chk("pre_rst_count", 64'(validCount), 64'(6'd3));
        wrEn = 2'b01; addrWr = {5'd0, 5'd7}; dataWr = {8'h00, 8'h77};
        reset = 1'b1; #1;
        chk("arst_ready", 64'(ramReady), 64'(1'b0));
        chk("arst_valid", 64'(valid), 64'(32'h0));
        chk("arst_count", 64'(validCount), 64'(6'd0));
        tick();
        reset = 1'b0; wrEn = 2'b00;
        for (int i = 0; i < 8; i++) begin
            chk("reinit_ready_low", 64'(ramReady), 64'(1'b0));
            tick();
        end
        addr = {5'd7, 5'd0}; #1;
        chk("reinit_ready_high", 64'(ramReady), 64'(1'b1));
        chk("reinit_valid", 64'(valid), 64'(32'h0));
        chk("reinit_count", 64'(validCount), 64'(6'd0));
        chk("reinit_data0", 64'(data[7:0]), 64'(8'h04));
        chk("reinit_data7", 64'(data[15:8]), 64'(8'h0B));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
